rob_core: RTL and testbench
===========================

ROB_CORE -- requirements
Module: rob_core

Interface
REQ-001 SHALL have parameter ROB_SIZE_BIT, default 3, log2 of entry count; ROB_SIZE = 2**ROB_SIZE_BIT.
REQ-002 SHALL have clk_in  input  1  clock; rst_in  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have rdy_in  input  1  global ready; low freezes all state.
REQ-004 SHALL have issue_valid, issue_has_rd  input  1 each; issue_rd  input  5; issue_ready, issue_mispred  input  1 each; issue_val, issue_target  input  32; entry allocation from decoder.
REQ-005 SHALL have rob_full  output  1; issue_tag  output  ROB_SIZE_BIT  tail index allocated this cycle.
REQ-006 SHALL have wb_valid  input  1; wb_tag  input  ROB_SIZE_BIT; wb_val, wb_target  input  32; wb_mispred  input  1; result broadcast.
REQ-007 SHALL have is_update_dep  output  1; update_dep_id  output  5; update_dep  output  ROB_SIZE_BIT; rename write to register file.
REQ-008 SHALL have is_update_val  output  1; update_val_id  output  5; update_val_dep  output  ROB_SIZE_BIT; update_val  output  32; commit write to register file.
REQ-009 SHALL have rob_clear  output  1; clear_pc  output  32; flush broadcast.
REQ-010 SHALL have qry1_tag, qry2_tag  input  ROB_SIZE_BIT; qry1_ready, qry2_ready  output  1; qry1_val, qry2_val  output  32; operand lookup.

Function
REQ-011 SHALL be a circular buffer: head, tail, count; per entry busy, ready, has_rd, rd, val, mispred, target.
REQ-012 SHALL drive rob_full = (count == ROB_SIZE) or clear_pending, from registered state only.
REQ-013 SHALL accept issue when rdy_in && issue_valid && !rob_full: write entry at tail, busy=1, ready=issue_ready, tail wraps ROB_SIZE-1 -> 0; issue_tag = tail combinationally.
REQ-014 SHALL assert is_update_dep combinationally in the accepting cycle iff issue_has_rd && issue_rd != 0, with update_dep_id=issue_rd, update_dep=tail.
REQ-015 SHALL on wb_valid with busy[wb_tag] set ready, val, mispred, target at next edge; wb to non-busy entry ignored.
REQ-016 SHALL commit at most one entry per cycle: head busy && ready (registered) && !clear_pending; commit clears busy, head wraps, count decrements.
REQ-017 SHALL assert is_update_val combinationally in the commit cycle iff has_rd && rd != 0, with update_val_id=rd, update_val_dep=head, update_val=val.
REQ-018 SHALL, when the committing entry has mispred=1, set clear_pending; next cycle rob_clear=1 (one cycle), clear_pc=entry target, all busy cleared, head=tail=count=0.
REQ-019 SHALL in clear_pending cycle refuse issue, suppress commit, ignore wb; is_update_dep/is_update_val held 0.
REQ-020 SHALL handle simultaneous issue and commit: count unchanged; issue when full refused even if commit same cycle.
REQ-021 SHALL have no commit when empty; wb to head takes effect one cycle later (commit next cycle earliest).
REQ-022 SHALL drive qryN_ready = busy && ready of entry, qryN_val = entry val.
REQ-023 SHALL with rdy_in low change no state and hold all strobe outputs (is_update_dep, is_update_val, rob_clear) at 0.

Reset
REQ-024 SHALL on rst_in clear head, tail, count, clear_pending, all busy/ready; all outputs 0 except issue_tag=0.
REQ-025 SHALL abandon any pending clear on reset mid-operation; no rob_clear pulse after reset.

Configuration
REQ-026 SHALL with ROB_WB_FORWARD_EN defined return qryN_ready=1, qryN_val=wb_val when wb_valid && wb_tag==qryN_tag && busy; without it query reflects registered state only.

Verification
REQ-027 Reset then issue rd=5 -> is_update_dep=1, update_dep_id=5, update_dep=0, issue_tag=0.
REQ-028 Issue 8 entries, no wb -> rob_full=1 after 8th; 9th issue_valid ignored, tail stays 0.
REQ-029 Issue tag0 rd=3, wb tag0 val=0x1234 -> next cycle is_update_val=1, update_val_id=3, update_val_dep=0, update_val=0x1234.
REQ-030 Issue branch tag0 + 2 entries, wb tag0 mispred=1 target=0x80 -> commit cycle, then rob_clear=1, clear_pc=0x80, count=0, rob_full=0 next cycle.
REQ-031 Full ROB, head ready, issue_valid same cycle -> commit occurs, issue refused, count=7.
REQ-032 Entry rd=0 issued and committed -> is_update_dep=0, is_update_val=0, head advances.

Source files
------------

// File: rtl/rob_core.sv
// Reorder buffer: in-order allocate/commit circular buffer with a one-cycle mispredict flush.
// Optional define ROB_WB_FORWARD_EN forwards a same-cycle writeback onto the operand query ports.
module rob_core #(
    parameter int ROB_SIZE_BIT = 3
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    issue_valid,
    input  logic                    issue_has_rd,
    input  logic [4:0]              issue_rd,
    input  logic                    issue_ready,
    input  logic                    issue_mispred,
    input  logic [31:0]             issue_val,
    input  logic [31:0]             issue_target,
    output logic                    rob_full,
    output logic [ROB_SIZE_BIT-1:0] issue_tag,
    input  logic                    wb_valid,
    input  logic [ROB_SIZE_BIT-1:0] wb_tag,
    input  logic [31:0]             wb_val,
    input  logic [31:0]             wb_target,
    input  logic                    wb_mispred,
    output logic                    is_update_dep,
    output logic [4:0]              update_dep_id,
    output logic [ROB_SIZE_BIT-1:0] update_dep,
    output logic                    is_update_val,
    output logic [4:0]              update_val_id,
    output logic [ROB_SIZE_BIT-1:0] update_val_dep,
    output logic [31:0]             update_val,
    output logic                    rob_clear,
    output logic [31:0]             clear_pc,
    input  logic [ROB_SIZE_BIT-1:0] qry1_tag,
    input  logic [ROB_SIZE_BIT-1:0] qry2_tag,
    output logic                    qry1_ready,
    output logic                    qry2_ready,
    output logic [31:0]             qry1_val,
    output logic [31:0]             qry2_val
);

    localparam int ROB_SIZE = 1 << ROB_SIZE_BIT;
    localparam logic [ROB_SIZE_BIT:0] FULL_COUNT = (ROB_SIZE_BIT + 1)'(ROB_SIZE);

    logic [ROB_SIZE_BIT-1:0] head;
    logic [ROB_SIZE_BIT-1:0] tail;
    logic [ROB_SIZE_BIT:0]   count;
    logic                    clear_pending;
    logic [31:0]             clear_target;

    logic [ROB_SIZE-1:0] busy;
    logic [ROB_SIZE-1:0] ready;
    logic [ROB_SIZE-1:0] has_rd;
    logic [ROB_SIZE-1:0] mispred;
    logic [4:0]          ent_rd     [ROB_SIZE];
    logic [31:0]         ent_val    [ROB_SIZE];
    logic [31:0]         ent_target [ROB_SIZE];

    logic do_issue;
    logic do_commit;
    logic wb_hit;

    assign rob_full  = (count == FULL_COUNT) || clear_pending;
    assign issue_tag = tail;
    assign do_issue  = rdy_in && issue_valid && !rob_full;
    assign do_commit = rdy_in && !clear_pending && busy[head] && ready[head];
    assign wb_hit    = rdy_in && !clear_pending && wb_valid && busy[wb_tag];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            clear_pending <= 1'b0;
            clear_target  <= '0;
            busy          <= '0;
            ready         <= '0;
            has_rd        <= '0;
            mispred       <= '0;
            for (int unsigned i = 0; i < ROB_SIZE; i++) begin
                ent_rd[i]     <= '0;
                ent_val[i]    <= '0;
                ent_target[i] <= '0;
            end
        end else if (rdy_in) begin
            if (clear_pending) begin
                head          <= '0;
                tail          <= '0;
                count         <= '0;
                busy          <= '0;
                ready         <= '0;
                clear_pending <= 1'b0;
            end else begin
                if (wb_hit) begin
                    ready[wb_tag]      <= 1'b1;
                    ent_val[wb_tag]    <= wb_val;
                    mispred[wb_tag]    <= wb_mispred;
                    ent_target[wb_tag] <= wb_target;
                end
                // Commit reads the pre-writeback head fields; a busy head is never the issue slot.
                if (do_commit) begin
                    busy[head] <= 1'b0;
                    head       <= head + 1'b1;
                    if (mispred[head]) begin
                        clear_pending <= 1'b1;
                        clear_target  <= ent_target[head];
                    end
                end
                if (do_issue) begin
                    busy[tail]       <= 1'b1;
                    ready[tail]      <= issue_ready;
                    has_rd[tail]     <= issue_has_rd;
                    mispred[tail]    <= issue_mispred;
                    ent_rd[tail]     <= issue_rd;
                    ent_val[tail]    <= issue_val;
                    ent_target[tail] <= issue_target;
                    tail             <= tail + 1'b1;
                end
                case ({do_issue, do_commit})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        is_update_dep  = 1'b0;
        update_dep_id  = '0;
        update_dep     = '0;
        is_update_val  = 1'b0;
        update_val_id  = '0;
        update_val_dep = '0;
        update_val     = '0;
        if (do_issue && issue_has_rd && (issue_rd != 5'd0)) begin
            is_update_dep = 1'b1;
            update_dep_id = issue_rd;
            update_dep    = tail;
        end
        if (do_commit && has_rd[head] && (ent_rd[head] != 5'd0)) begin
            is_update_val  = 1'b1;
            update_val_id  = ent_rd[head];
            update_val_dep = head;
            update_val     = ent_val[head];
        end
        rob_clear = rdy_in && clear_pending;
        clear_pc  = rob_clear ? clear_target : '0;
    end

    always_comb begin
        qry1_ready = busy[qry1_tag] && ready[qry1_tag];
        qry1_val   = ent_val[qry1_tag];
        qry2_ready = busy[qry2_tag] && ready[qry2_tag];
        qry2_val   = ent_val[qry2_tag];
`ifdef ROB_WB_FORWARD_EN
        if (wb_valid && (wb_tag == qry1_tag) && busy[qry1_tag]) begin
            qry1_ready = 1'b1;
            qry1_val   = wb_val;
        end
        if (wb_valid && (wb_tag == qry2_tag) && busy[qry2_tag]) begin
            qry2_ready = 1'b1;
            qry2_val   = wb_val;
        end
`endif
    end

endmodule

// File: tb/tb_rob_core.sv
// Bench for rob_core: directed vector table, hand-written corner sequences, then random traffic
// checked against a queue-based model of the reorder buffer.
module tb_rob_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rdy, iv, ihr, ir, imis, wv, wmis;
    logic [4:0]  ird;
    logic [31:0] ival, itgt, wval, wtgt;
    logic [2:0]  wtag, q1, q2;

    logic        full, dep_s, val_s, clr, q1r, q2r;
    logic [2:0]  itag, dep_tag, val_dep;
    logic [4:0]  dep_id, val_id;
    logic [31:0] uval, cpc, q1v, q2v;

    int total = 0;
    int bad   = 0;

    rob_core #(.ROB_SIZE_BIT(3)) dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
        .issue_valid(iv), .issue_has_rd(ihr), .issue_rd(ird), .issue_ready(ir),
        .issue_mispred(imis), .issue_val(ival), .issue_target(itgt),
        .rob_full(full), .issue_tag(itag),
        .wb_valid(wv), .wb_tag(wtag), .wb_val(wval), .wb_target(wtgt), .wb_mispred(wmis),
        .is_update_dep(dep_s), .update_dep_id(dep_id), .update_dep(dep_tag),
        .is_update_val(val_s), .update_val_id(val_id), .update_val_dep(val_dep), .update_val(uval),
        .rob_clear(clr), .clear_pc(cpc),
        .qry1_tag(q1), .qry2_tag(q2), .qry1_ready(q1r), .qry2_ready(q2r),
        .qry1_val(q1v), .qry2_val(q2v)
    );

    // Reference model: live entries in program order, oldest first.
    typedef struct {
        logic [2:0]  tag;
        logic        hr;
        logic [4:0]  rd;
        logic        rdyb;
        logic [31:0] val;
        logic        mis;
        logic [31:0] tgt;
    } ment_t;
    ment_t       mq[$];
    int          mtail = 0;
    bit          mpend = 0;
    logic [31:0] mpc = '0;

    typedef struct {
        logic iv, ihr, ir; logic [4:0] rd; logic [31:0] ival;
        logic wv; logic [2:0] wtag; logic [31:0] wval; logic [2:0] q1t;
    } vin_t;
    typedef struct {
        logic full; logic [2:0] itag; logic dep; logic [4:0] dep_id; logic [2:0] dep_tag;
        logic val; logic [4:0] val_id; logic [2:0] val_dep; logic [31:0] uval;
        logic q1r; logic [31:0] q1v;
    } vexp_t;
    vin_t  tin[9];
    vexp_t tex[9];

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic chkn(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        rdy = 1'b1; iv = 1'b0; ihr = 1'b0; ir = 1'b0; imis = 1'b0; ird = '0;
        ival = '0; itgt = '0; wv = 1'b0; wtag = '0; wval = '0; wtgt = '0; wmis = 1'b0;
        q1 = '0; q2 = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        mq.delete();
        mtail = 0;
        mpend = 0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic hr, input logic rd_ok, input logic [31:0] v);
        idle();
        iv = 1'b1; ihr = hr; ird = rd; ir = rd_ok; ival = v;
    endtask

    function automatic int find(input logic [2:0] t);
        foreach (mq[i]) if (mq[i].tag == t) return i;
        return -1;
    endfunction

    task automatic qexp(input logic [2:0] t, output logic r, output logic [31:0] v);
        int k;
        k = find(t);
        r = (k >= 0) && mq[k].rdyb;
        v = r ? mq[k].val : '0;
`ifdef ROB_WB_FORWARD_EN
        if (wv && wtag == t && k >= 0) begin
            r = 1'b1;
            v = wval;
        end
`endif
    endtask

    task automatic run_random(input int n);
        bit e_full, e_acc, e_com, e_dep, e_val, e_q1r, e_q2r;
        logic [31:0] e_q1v, e_q2v;
        ment_t h, nw;
        int k;
        for (int c = 0; c < n; c++) begin
            rdy  = ($urandom_range(0, 7) != 0);
            iv   = ($urandom_range(0, 2) != 0);
            ihr  = ($urandom_range(0, 3) != 0);
            ird  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            ir   = ($urandom_range(0, 3) == 0);
            imis = ir && ($urandom_range(0, 15) == 0);
            ival = $urandom;
            itgt = $urandom;
            wv   = ($urandom_range(0, 1) != 0);
            if (mq.size() > 0 && $urandom_range(0, 4) != 0)
                wtag = mq[$urandom_range(0, mq.size() - 1)].tag;
            else
                wtag = 3'($urandom_range(0, 7));
            wval = $urandom;
            wtgt = $urandom;
            wmis = ($urandom_range(0, 11) == 0);
            q1   = 3'($urandom_range(0, 7));
            q2   = 3'($urandom_range(0, 7));
            sample();
            e_full = (mq.size() == 8) || mpend;
            e_acc  = rdy && iv && !e_full;
            e_com  = rdy && !mpend && mq.size() > 0 && mq[0].rdyb;
            e_dep  = e_acc && ihr && ird != 5'd0;
            e_val  = e_com && mq[0].hr && mq[0].rd != 5'd0;
            chk1($sformatf("rnd%0d.full", c), full, e_full);
            chkn($sformatf("rnd%0d.itag", c), 32'(itag), 32'(mtail));
            chk1($sformatf("rnd%0d.dep", c), dep_s, e_dep);
            if (e_dep) begin
                chkn($sformatf("rnd%0d.dep_id", c), 32'(dep_id), 32'(ird));
                chkn($sformatf("rnd%0d.dep_tag", c), 32'(dep_tag), 32'(mtail));
            end
            chk1($sformatf("rnd%0d.commit", c), val_s, e_val);
            if (e_val) begin
                chkn($sformatf("rnd%0d.val_id", c), 32'(val_id), 32'(mq[0].rd));
                chkn($sformatf("rnd%0d.val_dep", c), 32'(val_dep), 32'(mq[0].tag));
                chkn($sformatf("rnd%0d.uval", c), uval, mq[0].val);
            end
            chk1($sformatf("rnd%0d.clear", c), clr, rdy && mpend);
            if (rdy && mpend) chkn($sformatf("rnd%0d.clear_pc", c), cpc, mpc);
            qexp(q1, e_q1r, e_q1v);
            qexp(q2, e_q2r, e_q2v);
            chk1($sformatf("rnd%0d.q1r", c), q1r, e_q1r);
            chk1($sformatf("rnd%0d.q2r", c), q2r, e_q2r);
            if (e_q1r) chkn($sformatf("rnd%0d.q1v", c), q1v, e_q1v);
            if (e_q2r) chkn($sformatf("rnd%0d.q2v", c), q2v, e_q2v);
            @(posedge clk);
            if (rdy) begin
                if (mpend) begin
                    mq.delete();
                    mtail = 0;
                    mpend = 0;
                end else begin
                    if (e_com) h = mq[0];
                    if (wv) begin
                        k = find(wtag);
                        if (k >= 0) begin
                            mq[k].rdyb = 1'b1; mq[k].val = wval; mq[k].mis = wmis; mq[k].tgt = wtgt;
                        end
                    end
                    if (e_com) begin
                        if (h.mis) begin
                            mpend = 1;
                            mpc   = h.tgt;
                        end
                        void'(mq.pop_front());
                    end
                    if (e_acc) begin
                        nw.tag = 3'(mtail); nw.hr = ihr; nw.rd = ird; nw.rdyb = ir;
                        nw.val = ival; nw.mis = imis; nw.tgt = itgt;
                        mq.push_back(nw);
                        mtail = (mtail + 1) % 8;
                    end
                end
            end
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst = 1'b1;
        sample();
        chk1("reset.full", full, 1'b0);
        chkn("reset.itag", 32'(itag), 32'd0);
        chk1("reset.dep", dep_s, 1'b0);
        chk1("reset.commit", val_s, 1'b0);
        chk1("reset.clear", clr, 1'b0);
        chkn("reset.clear_pc", cpc, 32'd0);
        chk1("reset.q1r", q1r, 1'b0);
        chkn("reset.q1v", q1v, 32'd0);
        tick();
        rst = 1'b0;

        // Directed table: rename, writeback, commit ordering and rd=0 handling.
        tin[0] = '{1'b1, 1'b1, 1'b0, 5'd5, 32'h0,  1'b0, 3'd0, 32'h0,    3'd0};
        tex[0] = '{1'b0, 3'd0, 1'b1, 5'd5, 3'd0, 1'b0, 5'd0, 3'd0, 32'h0,    1'b0, 32'h0};
        tin[1] = '{1'b1, 1'b1, 1'b1, 5'd0, 32'h55, 1'b1, 3'd0, 32'h1234, 3'd0};
        tex[1] = '{1'b0, 3'd1, 1'b0, 5'd0, 3'd0, 1'b0, 5'd0, 3'd0, 32'h0,    1'b0, 32'h0};
        tin[2] = '{1'b0, 1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 3'd0, 32'h0,    3'd0};
        tex[2] = '{1'b0, 3'd2, 1'b0, 5'd0, 3'd0, 1'b1, 5'd5, 3'd0, 32'h1234, 1'b1, 32'h1234};
        tin[3] = '{1'b0, 1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 3'd0, 32'h0,    3'd1};
        tex[3] = '{1'b0, 3'd2, 1'b0, 5'd0, 3'd0, 1'b0, 5'd0, 3'd0, 32'h0,    1'b1, 32'h55};
        tin[4] = '{1'b1, 1'b1, 1'b0, 5'd3, 32'h0,  1'b0, 3'd0, 32'h0,    3'd1};
        tex[4] = '{1'b0, 3'd2, 1'b1, 5'd3, 3'd2, 1'b0, 5'd0, 3'd0, 32'h0,    1'b0, 32'h0};
        tin[5] = '{1'b0, 1'b0, 1'b0, 5'd0, 32'h0,  1'b1, 3'd2, 32'hBEEF, 3'd2};
        tex[5] = '{1'b0, 3'd3, 1'b0, 5'd0, 3'd0, 1'b0, 5'd0, 3'd0, 32'h0,    1'b0, 32'h0};
        tin[6] = '{1'b0, 1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 3'd0, 32'h0,    3'd2};
        tex[6] = '{1'b0, 3'd3, 1'b0, 5'd0, 3'd0, 1'b1, 5'd3, 3'd2, 32'hBEEF, 1'b1, 32'hBEEF};
        tin[7] = '{1'b0, 1'b0, 1'b0, 5'd0, 32'h0,  1'b1, 3'd4, 32'hDEAD, 3'd4};
        tex[7] = '{1'b0, 3'd3, 1'b0, 5'd0, 3'd0, 1'b0, 5'd0, 3'd0, 32'h0,    1'b0, 32'h0};
        tin[8] = '{1'b0, 1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 3'd0, 32'h0,    3'd4};
        tex[8] = '{1'b0, 3'd3, 1'b0, 5'd0, 3'd0, 1'b0, 5'd0, 3'd0, 32'h0,    1'b0, 32'h0};
`ifdef ROB_WB_FORWARD_EN
        tex[1].q1r = 1'b1; tex[1].q1v = 32'h1234;
        tex[5].q1r = 1'b1; tex[5].q1v = 32'hBEEF;
`endif
        for (int i = 0; i < 9; i++) begin
            idle();
            iv = tin[i].iv; ihr = tin[i].ihr; ir = tin[i].ir; ird = tin[i].rd; ival = tin[i].ival;
            wv = tin[i].wv; wtag = tin[i].wtag; wval = tin[i].wval; q1 = tin[i].q1t;
            sample();
            chk1($sformatf("vec%0d.full", i), full, tex[i].full);
            chkn($sformatf("vec%0d.itag", i), 32'(itag), 32'(tex[i].itag));
            chk1($sformatf("vec%0d.dep", i), dep_s, tex[i].dep);
            if (tex[i].dep) begin
                chkn($sformatf("vec%0d.dep_id", i), 32'(dep_id), 32'(tex[i].dep_id));
                chkn($sformatf("vec%0d.dep_tag", i), 32'(dep_tag), 32'(tex[i].dep_tag));
            end
            chk1($sformatf("vec%0d.commit", i), val_s, tex[i].val);
            if (tex[i].val) begin
                chkn($sformatf("vec%0d.val_id", i), 32'(val_id), 32'(tex[i].val_id));
                chkn($sformatf("vec%0d.val_dep", i), 32'(val_dep), 32'(tex[i].val_dep));
                chkn($sformatf("vec%0d.uval", i), uval, tex[i].uval);
            end
            chk1($sformatf("vec%0d.q1r", i), q1r, tex[i].q1r);
            if (tex[i].q1r) chkn($sformatf("vec%0d.q1v", i), q1v, tex[i].q1v);
            tick();
        end

        // Fill, overflow attempt, then commit racing a refused issue.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            issue(5'(i + 1), 1'b1, 1'b0, 32'h0);
            sample();
            chkn($sformatf("fill%0d.itag", i), 32'(itag), 32'(i));
            chk1($sformatf("fill%0d.full", i), full, 1'b0);
            tick();
        end
        issue(5'd9, 1'b1, 1'b0, 32'h0);
        sample();
        chk1("over.full", full, 1'b1);
        chk1("over.dep", dep_s, 1'b0);
        chkn("over.itag", 32'(itag), 32'd0);
        tick();
        idle();
        sample();
        chkn("over.tail_kept", 32'(itag), 32'd0);
        chk1("over.no_commit", val_s, 1'b0);
        tick();
        idle();
        wv = 1'b1; wtag = 3'd0; wval = 32'hA0;
        sample();
        chk1("fullwb.no_commit", val_s, 1'b0);
        tick();
        issue(5'd10, 1'b1, 1'b0, 32'h0);
        sample();
        chk1("race.commit", val_s, 1'b1);
        chkn("race.val_id", 32'(val_id), 32'd1);
        chkn("race.uval", uval, 32'hA0);
        chk1("race.refused", dep_s, 1'b0);
        chk1("race.full", full, 1'b1);
        tick();
        idle();
        sample();
        chk1("race.count7", full, 1'b0);
        chkn("race.itag", 32'(itag), 32'd0);
        tick();
        issue(5'd11, 1'b1, 1'b0, 32'h0);
        sample();
        chk1("refill.dep", dep_s, 1'b1);
        chkn("refill.dep_tag", 32'(dep_tag), 32'd0);
        tick();
        idle();
        sample();
        chk1("refill.full", full, 1'b1);
        tick();

        // Mispredicted branch at head flushes younger entries.
        do_reset();
        issue(5'd1, 1'b1, 1'b0, 32'h0);
        tick();
        issue(5'd2, 1'b1, 1'b1, 32'h22);
        tick();
        issue(5'd3, 1'b1, 1'b0, 32'h0);
        tick();
        idle();
        wv = 1'b1; wtag = 3'd0; wval = 32'h4; wmis = 1'b1; wtgt = 32'h80;
        sample();
        chk1("br.wb_cycle_clear", clr, 1'b0);
        tick();
        idle();
        sample();
        chk1("br.commit", val_s, 1'b1);
        chkn("br.val_id", 32'(val_id), 32'd1);
        chk1("br.commit_clear", clr, 1'b0);
        chk1("br.commit_full", full, 1'b0);
        tick();
        issue(5'd4, 1'b1, 1'b0, 32'h0);
        wv = 1'b1; wtag = 3'd2; wval = 32'h99;
        sample();
        chk1("flush.clear", clr, 1'b1);
        chkn("flush.pc", cpc, 32'h80);
        chk1("flush.full", full, 1'b1);
        chk1("flush.no_issue", dep_s, 1'b0);
        chk1("flush.no_commit", val_s, 1'b0);
        tick();
        idle();
        q1 = 3'd1;
        sample();
        chk1("postflush.clear", clr, 1'b0);
        chk1("postflush.full", full, 1'b0);
        chkn("postflush.itag", 32'(itag), 32'd0);
        chk1("postflush.q1r", q1r, 1'b0);
        chk1("postflush.no_commit", val_s, 1'b0);
        tick();

        // Global stall, then reset landing on a pending clear.
        do_reset();
        issue(5'd7, 1'b1, 1'b1, 32'h77);
        rdy = 1'b0;
        sample();
        chk1("stall.dep", dep_s, 1'b0);
        chkn("stall.itag", 32'(itag), 32'd0);
        tick();
        idle();
        sample();
        chkn("stall.tail_kept", 32'(itag), 32'd0);
        chk1("stall.empty", val_s, 1'b0);
        tick();
        issue(5'd7, 1'b1, 1'b1, 32'h77);
        sample();
        chk1("stall2.dep", dep_s, 1'b1);
        tick();
        idle();
        rdy = 1'b0;
        sample();
        chk1("stall2.no_commit", val_s, 1'b0);
        tick();
        idle();
        sample();
        chk1("stall2.commit", val_s, 1'b1);
        chkn("stall2.uval", uval, 32'h77);
        tick();
        issue(5'd0, 1'b0, 1'b1, 32'h0);
        imis = 1'b1; itgt = 32'h44;
        tick();
        idle();
        sample();
        chk1("rstclr.commit_cycle", clr, 1'b0);
        tick();
        rst = 1'b1;
        sample();
        chk1("rstclr.clear", clr, 1'b0);
        chk1("rstclr.full", full, 1'b0);
        chkn("rstclr.itag", 32'(itag), 32'd0);
        tick();
        rst = 1'b0;
        sample();
        chk1("rstclr.after", clr, 1'b0);
        chk1("rstclr.after_full", full, 1'b0);
        tick();

        do_reset();
        run_random(3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
